fetch_stage: RTL
================

Name: fetch_stage

Overview:
Fetch stage, directly upstream of the decode stage. Owns the program counter and issues word requests to a variable-latency instruction memory, at most one outstanding. Registers the returned instruction and its PC into the fetch/decode pipeline register. Supports decode stall, and redirect/flush from a taken branch resolved in execute.

Parameters:
N, 32, data/address width in bits
RESET_PC, 32'h0000_0000, PC value loaded on reset
PC_OFFSET, 8, value added to the fetched PC to form the decode-visible PC (R15 read value)

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
stall_d  input  1  decode cannot accept; hold the F/D register
branch_taken  input  1  execute resolved a taken branch this cycle
branch_target  input  N  redirect address, word aligned
imem_req  output  1  request valid to instruction memory
imem_addr  output  N  request address (current PC)
imem_gnt  input  1  memory accepted the request this cycle
imem_rvalid  input  1  read data valid
imem_rdata  input  N  instruction word
fd_valid  output  1  F/D register holds a real instruction
fd_inst  output  N  instruction to decode (0 when not valid)
fd_pc  output  N  fetched PC + PC_OFFSET

Behaviour:
- Reset (async, rst_n=0): pc=RESET_PC, state=REQ, imem_req=0, fd_valid=0, fd_inst=0, fd_pc=0, hold buffer empty. First request is issued the cycle after rst_n deasserts.
- Request handshake: imem_req=1 and imem_addr=pc while state=REQ. Request is accepted when imem_gnt=1; pc<=pc+4 in that cycle; state->WAIT. imem_addr and imem_req stay stable until granted.
- States:
  - REQ: request pending.
  - WAIT: one request outstanding.
  - HOLD: response received while stall_d=1. Instruction and PC are kept in a one-entry hold buffer.
  - DROP: redirect occurred while a response is still outstanding; the returning data is discarded.
- WAIT + imem_rvalid:
  - stall_d=0: load F/D with {1, rdata, req_pc+PC_OFFSET}; state->REQ. Request may assert that same cycle.
  - stall_d=1: store in hold buffer; state->HOLD.
- HOLD: when stall_d falls, move the hold buffer to F/D the next edge; state->REQ. No new request is issued while in HOLD.
- stall_d=1: F/D register keeps its contents unchanged; no other side effect.
- Branch (highest priority, overrides stall_d):
  - pc<=branch_target; fd_valid<=0; fd_inst<=0; hold buffer cleared.
  - State WAIT with no rvalid in that cycle -> DROP.
  - rvalid in that same cycle -> discard it; state->REQ.
  - Otherwise -> REQ.
  - A request granted in the same cycle as branch_taken is considered outstanding; -> DROP.
- DROP: the next imem_rvalid is discarded; state->REQ. branch_taken in DROP updates pc and stays in DROP.
- Bubble: cycles where F/D is loaded with nothing drive fd_valid=0 and fd_inst=0. fd_pc holds its last value.
- Arithmetic: pc+4 and pc+PC_OFFSET are modulo 2^N; wrap at 0xFFFF_FFFC -> 0 is silent. Branch target low two bits are forced to 0.
- Latency: best case, grant in cycle t and rvalid in t+1 puts fd_valid in t+2. Throughput is one instruction per 2 cycles with a 1-cycle memory.
- imem_rvalid outside WAIT/DROP is ignored.

Optional Feature:
FETCH_PERF_CNT_EN
- Defined: adds outputs perf_fetched (32 bit, increments on every F/D load with fd_valid=1), perf_stall (32 bit, increments each cycle stall_d=1 && fd_valid=1) and perf_flush (16 bit, increments per branch_taken). All counters saturate, are cleared by rst_n, and their ports exist only when the macro is defined.
- Undefined: no counters and no extra ports; behaviour otherwise identical.

Decomposition:
- Shared pipeline package gains:
  - fetch_state_t enum {REQ, WAIT, HOLD, DROP}
  - fetch_deco_interface struct {valid, inst, pc}, used as the decode-stage input
  - constants INST_NOP=32'h0 and PC_STEP=4
- Natural sub-module: fd_hold_buffer, the one-entry holding register with load/clear/valid. The FSM and PC stay in fetch_stage.

Test Plan:
- Reset: rst_n low mid-WAIT -> all outputs 0 immediately. After release, imem_addr=0x0 with imem_req=1 the next cycle.
- Sequential fetch, gnt=1 always, rvalid 1 cycle later -> fd_pc sequence 0x8, 0xC, 0x10 with matching fd_inst, fd_valid pulses every 2 cycles.
- Stall: rvalid for inst 0xE3A01005 while stall_d=1 for 3 cycles -> F/D unchanged, no imem_req. One cycle after stall_d falls, fd_inst=0xE3A01005.
- Branch while WAIT, target 0x100 -> late rvalid discarded, next imem_addr=0x100, fd_valid=0 until the 0x100 word arrives with fd_pc=0x108.
- Branch with stall_d=1 and HOLD full -> buffer cleared, fd_valid=0, next request is 0x100.
- Wrap: RESET_PC=0xFFFF_FFFC -> second request address 0x0; fd_pc of the first instruction = 0x4.

Source files
------------

// File: rtl/fetch_stage_pkg.sv
// Shared pipeline types and constants used by the fetch stage and the decode-stage input.
package fetch_stage_pkg;

   localparam int XLEN = 32;

   typedef enum logic [1:0] {
      REQ  = 2'd0,
      WAIT = 2'd1,
      HOLD = 2'd2,
      DROP = 2'd3
   } fetch_state_t;

   typedef struct packed {
      logic            valid;
      logic [XLEN-1:0] inst;
      logic [XLEN-1:0] pc;
   } fetch_deco_interface;

   localparam logic [XLEN-1:0] INST_NOP = 32'h0000_0000;
   localparam int              PC_STEP  = 4;

endpackage

// File: rtl/fd_hold_buffer.sv
// One-entry buffer that parks a returned instruction and its decode-visible PC while decode stalls.
module fd_hold_buffer #(
   parameter int N = 32
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         load,
   input  logic         clear,
   input  logic [N-1:0] inst_in,
   input  logic [N-1:0] pc_in,
   output logic         valid,
   output logic [N-1:0] inst,
   output logic [N-1:0] pc
);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid <= 1'b0;
         inst  <= '0;
         pc    <= '0;
      end else if (clear) begin
         valid <= 1'b0;
         inst  <= '0;
         pc    <= '0;
      end else if (load) begin
         valid <= 1'b1;
         inst  <= inst_in;
         pc    <= pc_in;
      end
   end

endmodule

// File: rtl/fetch_stage.sv
// Fetch stage: PC, single-outstanding imem handshake, F/D pipeline register.
// Optional saturating perf counters when FETCH_PERF_CNT_EN is defined.
//
// state | meaning
// REQ   | request pending on imem (imem_req high once out of reset)
// WAIT  | one request outstanding, waiting for imem_rvalid
// HOLD  | response parked in hold buffer while decode stalls
// DROP  | redirected with a response still in flight; discard it
module fetch_stage
   import fetch_stage_pkg::*;
#(
   parameter int           N         = 32,
   parameter logic [N-1:0] RESET_PC  = '0,
   parameter int           PC_OFFSET = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         stall_d,
   input  logic         branch_taken,
   input  logic [N-1:0] branch_target,
   output logic         imem_req,
   output logic [N-1:0] imem_addr,
   input  logic         imem_gnt,
   input  logic         imem_rvalid,
   input  logic [N-1:0] imem_rdata,
   output logic         fd_valid,
   output logic [N-1:0] fd_inst,
   output logic [N-1:0] fd_pc
`ifdef FETCH_PERF_CNT_EN
   ,
   output logic [31:0]  perf_fetched,
   output logic [31:0]  perf_stall,
   output logic [15:0]  perf_flush
`endif
);

   fetch_state_t state_q, state_d;
   logic [N-1:0] pc_q;
   logic [N-1:0] req_pc_q;
   logic [N-1:0] target_al;
   logic [N-1:0] rsp_pc;
   logic         grant;
   logic         rsp;
   logic         hold_load;
   logic         hold_clear;
   logic         hold_xfer;
   logic         hold_valid;
   logic [N-1:0] hold_inst;
   logic [N-1:0] hold_pc;
   logic         fd_load_valid;

   assign target_al  = branch_target & ~N'(3);
   assign rsp_pc     = req_pc_q + N'(PC_OFFSET);
   assign grant      = imem_req && imem_gnt && (state_q == REQ);
   assign rsp        = imem_rvalid && (state_q == WAIT);
   assign hold_xfer  = (state_q == HOLD) && !stall_d && !branch_taken;
   assign hold_load  = rsp && stall_d && !branch_taken;
   assign hold_clear = branch_taken || hold_xfer;
   assign imem_addr  = pc_q;

   assign fd_load_valid = !branch_taken &&
                          ((rsp && !stall_d) || (hold_xfer && hold_valid));

   always_comb begin
      state_d = state_q;
      case (state_q)
         REQ:  if (grant) state_d = branch_taken ? DROP : WAIT;
         WAIT: begin
            if (branch_taken)     state_d = imem_rvalid ? REQ : DROP;
            else if (imem_rvalid) state_d = stall_d ? HOLD : REQ;
         end
         HOLD: if (branch_taken || !stall_d) state_d = REQ;
         // The in-flight word retiring here leaves nothing outstanding, so a
         // coincident redirect must not keep waiting for another response.
         DROP: if (imem_rvalid) state_d = REQ;
         default: state_d = REQ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= REQ;
         imem_req <= 1'b0;
         pc_q     <= RESET_PC;
         req_pc_q <= RESET_PC;
         fd_valid <= 1'b0;
         fd_inst  <= '0;
         fd_pc    <= '0;
      end else begin
         state_q  <= state_d;
         imem_req <= (state_d == REQ);

         if (branch_taken)  pc_q <= target_al;
         else if (grant)    pc_q <= pc_q + N'(PC_STEP);
         if (grant)         req_pc_q <= pc_q;

         if (branch_taken) begin
            fd_valid <= 1'b0;
            fd_inst  <= N'(INST_NOP);
         end else if (rsp && !stall_d) begin
            fd_valid <= 1'b1;
            fd_inst  <= imem_rdata;
            fd_pc    <= rsp_pc;
         end else if (hold_xfer) begin
            fd_valid <= hold_valid;
            fd_inst  <= hold_inst;
            fd_pc    <= hold_pc;
         end else if (!stall_d) begin
            fd_valid <= 1'b0;
            fd_inst  <= N'(INST_NOP);
         end
      end
   end

   fd_hold_buffer #(.N(N)) u_hold (
      .clk     (clk),
      .rst_n   (rst_n),
      .load    (hold_load),
      .clear   (hold_clear),
      .inst_in (imem_rdata),
      .pc_in   (rsp_pc),
      .valid   (hold_valid),
      .inst    (hold_inst),
      .pc      (hold_pc)
   );

`ifdef FETCH_PERF_CNT_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         perf_fetched <= '0;
         perf_stall   <= '0;
         perf_flush   <= '0;
      end else begin
         if (fd_load_valid && (perf_fetched != '1))     perf_fetched <= perf_fetched + 32'd1;
         if (stall_d && fd_valid && (perf_stall != '1)) perf_stall   <= perf_stall + 32'd1;
         if (branch_taken && (perf_flush != '1))        perf_flush   <= perf_flush + 16'd1;
      end
   end
`else
   logic unused_load_valid;
   assign unused_load_valid = fd_load_valid;
`endif

endmodule
